dft_frame_sequencer: RTL

DFT_FRAME_SEQUENCER -- requirements
Module: dft_frame_sequencer

---
 rtl/dft_frame_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dft_frame_sequencer.sv
// Frame sequencer for a streaming DFT datapath.
// Latches a frame length N on trigger, clears the accumulators and resets the
// oscillator bank, streams N samples (window address = sample index), waits
// for the accumulator result with a timeout, then holds the result for the
// downstream handshake. Continuous mode re-arms directly from HOLD.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   cfg_num_samples_i, cont_i, trig_i  frame configuration and start
//   abort_i, clr_err_i                 abort frame, clear sticky errors
//   in_valid_i / in_ready_o            upstream sample handshake
//   acc_start_o, acc_sample_valid_o,
//   acc_last_sample_o, acc_valid_i     DFT accumulator control / result
//   osc_reset_o, osc_advance_o         oscillator bank control
//   win_addr_o                         window ROM address
//   res_valid_o / res_ready_i          downstream result handshake
//   frame_cnt_o, busy_o, err_*_o       status
module dft_frame_sequencer #(
   parameter int unsigned SAMPLE_COUNT_WIDTH = 16,
   parameter int unsigned FRAME_CNT_WIDTH    = 16,
   parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [SAMPLE_COUNT_WIDTH-1:0] cfg_num_samples_i,
   input  logic                          cont_i,
   input  logic                          trig_i,
   input  logic                          abort_i,
   input  logic                          clr_err_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   output logic                          acc_start_o,
   output logic                          acc_sample_valid_o,
   output logic                          acc_last_sample_o,
   input  logic                          acc_valid_i,
   output logic                          osc_reset_o,
   output logic                          osc_advance_o,
   output logic [SAMPLE_COUNT_WIDTH-1:0] win_addr_o,
   output logic                          res_valid_o,
   input  logic                          res_ready_i,
   output logic [FRAME_CNT_WIDTH-1:0]    frame_cnt_o,
   output logic                          busy_o,
   output logic                          err_cfg_o,
   output logic                          err_timeout_o,
   output logic                          err_overrun_o
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      STREAM   = 3'd2,
      WAIT_ACC = 3'd3,
      HOLD     = 3'd4
   } state_t;

   state_t                        state_q, state_d;
   logic [SAMPLE_COUNT_WIDTH-1:0] n_q, n_d;
   logic [SAMPLE_COUNT_WIDTH-1:0] idx_q, idx_d;
   logic [TMO_W-1:0]              tmo_q, tmo_d;
   logic [FRAME_CNT_WIDTH-1:0]    frame_cnt_d;
   logic                          kill;
   logic                          accept;
   logic                          is_last;
   logic                          set_cfg, set_tmo, set_ovr;

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         n_q           <= '0;
         idx_q         <= '0;
         tmo_q         <= '0;
         frame_cnt_o   <= '0;
         err_cfg_o     <= 1'b0;
         err_timeout_o <= 1'b0;
         err_overrun_o <= 1'b0;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         idx_q         <= idx_d;
         tmo_q         <= tmo_d;
         frame_cnt_o   <= frame_cnt_d;
         // Sticky flags: a set event in the same cycle beats the clear
         err_cfg_o     <= (err_cfg_o     & ~clr_err_i) | set_cfg;
         err_timeout_o <= (err_timeout_o & ~clr_err_i) | set_tmo;
         err_overrun_o <= (err_overrun_o & ~clr_err_i) | set_ovr;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d            = state_q;
      n_d                = n_q;
      idx_d              = idx_q;
      tmo_d              = tmo_q;
      frame_cnt_d        = frame_cnt_o;
      set_cfg            = 1'b0;
      set_tmo            = 1'b0;
      in_ready_o         = 1'b0;
      acc_start_o        = 1'b0;
      osc_reset_o        = 1'b0;
      res_valid_o        = 1'b0;
      win_addr_o         = '0;

      // Abort or reset silences every strobe in the cycle it is seen
      kill   = abort_i | rst_i;
      busy_o = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (trig_i) begin
               if (cfg_num_samples_i != '0) begin
                  n_d     = cfg_num_samples_i;
                  state_d = START;
               end else begin
                  set_cfg = 1'b1;
               end
            end
         end
         START: begin
            acc_start_o = ~kill;
            osc_reset_o = ~kill;
            idx_d       = '0;
            state_d     = STREAM;
         end
         STREAM: begin
            in_ready_o = ~kill;
            win_addr_o = kill ? '0 : idx_q;
            tmo_d      = '0;
         end
         WAIT_ACC: begin
            if (acc_valid_i) begin
               state_d = HOLD;
            end else if (tmo_q == TMO_LAST) begin
               set_tmo = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         HOLD: begin
            res_valid_o = ~kill;
            if (res_ready_i) begin
               frame_cnt_d = frame_cnt_o + FRAME_CNT_WIDTH'(1);
               state_d     = IDLE;
               if (cont_i) begin
                  if (cfg_num_samples_i != '0) begin
                     n_d     = cfg_num_samples_i;
                     state_d = START;
                  end else begin
                     set_cfg = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Sample acceptance is combinational so the accumulator sees it same cycle
      accept             = in_valid_i & in_ready_o;
      is_last            = accept & (idx_q == (n_q - SAMPLE_COUNT_WIDTH'(1)));
      acc_sample_valid_o = accept;
      osc_advance_o      = accept;
      acc_last_sample_o  = is_last;
      if (accept) begin
         if (is_last) state_d = WAIT_ACC;
         else         idx_d   = idx_q + SAMPLE_COUNT_WIDTH'(1);
      end

      set_ovr = cont_i & in_valid_i & ~in_ready_o & busy_o;

      // Abort wins over trigger, accumulator result and result handshake
      if (abort_i) begin
         state_d     = IDLE;
         n_d         = n_q;
         idx_d       = '0;
         frame_cnt_d = frame_cnt_o;
         set_cfg     = 1'b0;
         set_tmo     = 1'b0;
      end
   end

endmodule
